// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE/FETCH/HOLD with deferred branch redirect.
// Optional memory-timeout detection when FETCH_TIMEOUT_EN is defined.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC       = 32'd0,
  parameter int          TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazardDetected,
  input  logic        PCSrcD,
  input  logic [31:0] PCbranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] instruction,
  output logic        valid_F,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic        req_q;
  logic        redir_pend_q;
  logic [31:0] redir_tgt_q;

  logic        pcsrc_qual_d;
  logic [31:0] pc_inc_d;

  assign pcsrc_qual_d = PCSrcD & ~hazardDetected;
  assign pc_inc_d     = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= 32'd0;
      valid_q      <= 1'b0;
      req_q        <= 1'b0;
      redir_pend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            // A same-cycle branch beats any older pending target; either way the word is stale.
            redir_pend_q <= 1'b0;
            if (pcsrc_qual_d) begin
              pc_q <= PCbranchD;
            end else if (redir_pend_q) begin
              pc_q <= redir_tgt_q;
            end else begin
              instr_q <= imem_rdata;
              valid_q <= 1'b1;
              state_q <= HOLD;
              req_q   <= 1'b0;
            end
          end else if (pcsrc_qual_d) begin
            redir_pend_q <= 1'b1;
            redir_tgt_q  <= PCbranchD;
          end
        end
        HOLD: begin
          if (!hazardDetected) begin
            pc_q    <= PCSrcD ? PCbranchD : pc_inc_d;
            valid_q <= 1'b0;
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT_CYCLES);

  logic [7:0] tmo_cnt_q;
  logic       err_q;

  // Counter sits at zero outside FETCH, so every entry to FETCH starts a fresh count.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      if (state_q != FETCH || imem_ack) begin
        tmo_cnt_q <= 8'd0;
      end else if (tmo_cnt_q != TMO_LIM) begin
        tmo_cnt_q <= tmo_cnt_q + 8'd1;
      end
      if (state_q == FETCH && !imem_ack && tmo_cnt_q == TMO_LIM - 8'd1) begin
        err_q <= 1'b1;
      end
    end
  end

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign PC          = pc_q;
  assign instruction = instr_q;
  assign valid_F     = valid_q;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'd0, address of the first fetch after reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 15, number of FETCH cycles without imem_ack before the error flag sets; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 hazardDetected  input  1  decode stall; when high, the held instruction is not consumed and PCSrcD is ignored.
REQ-006 PCSrcD  input  1  branch taken from decode; qualified by !hazardDetected.
REQ-007 PCbranchD  input  32  branch target, sampled when PCSrcD is qualified.
REQ-008 imem_req  output  1  instruction-memory request; equals (state==FETCH).
REQ-009 imem_addr  output  32  fetch address; equals PC.
REQ-010 imem_ack  input  1  memory response valid, sampled only while imem_req is high.
REQ-011 imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-012 PC  output  32  address of the word being fetched, or of the held word in HOLD.
REQ-013 instruction  output  32  registered instruction to decode.
REQ-014 valid_F  output  1  instruction holds a live word; high only in HOLD.
REQ-015 fetch_err  output  1  sticky memory-timeout flag.

Function
REQ-016 States: IDLE, FETCH, HOLD; 2-bit encoding; redirect_pending (1 bit) and redirect_target (32 bits) are held in registers.
REQ-017 IDLE -> FETCH unconditionally on the next clock; IDLE is entered only from reset.
REQ-018 In FETCH, PC shall stay stable until the cycle imem_ack is sampled high; the latency of imem_ack is unbounded.
REQ-019 In FETCH, imem_ack high with no redirect pending and no qualified PCSrcD gives: instruction<=imem_rdata, valid_F<=1, state->HOLD.
REQ-020 In FETCH, a qualified PCSrcD without imem_ack sets redirect_pending=1 and redirect_target=PCbranchD; a later qualified PCSrcD overwrites the target.
REQ-021 In FETCH, imem_ack high with a redirect pending gives: data discarded, PC<=redirect_target, redirect_pending<=0, stay FETCH; imem_req stays high.
REQ-022 In FETCH, imem_ack and a qualified PCSrcD in the same cycle give: data discarded, PC<=PCbranchD (the new target wins over any pending target), stay FETCH.
REQ-023 In HOLD with hazardDetected=1: PC, instruction and valid_F are held; PCSrcD is ignored.
REQ-024 In HOLD with hazardDetected=0: PC<=PCSrcD ? PCbranchD : PC+4, valid_F<=0, state->FETCH.
REQ-025 instruction keeps its last value when valid_F=0.
REQ-026 PC+4 is modulo 2^32: 32'hFFFFFFFC wraps to 32'h00000000.
REQ-027 imem_rdata is ignored whenever imem_ack is low or state is not FETCH.

Reset
REQ-028 rst high at posedge gives: state=IDLE, PC=RESET_PC, instruction=32'd0, valid_F=0, redirect_pending=0, imem_req=0, fetch_err=0, timeout counter=0.
REQ-029 rst high during FETCH abandons the outstanding request; an imem_ack arriving in the cycles after reset shall be ignored.

Configuration
REQ-030 Macro FETCH_TIMEOUT_EN: when defined, an 8-bit counter clears on entry to FETCH and on every imem_ack, and increments each FETCH cycle without ack, saturating at TIMEOUT_CYCLES.
REQ-031 With FETCH_TIMEOUT_EN, the counter reaching TIMEOUT_CYCLES sets fetch_err=1 until rst; the FSM keeps requesting.
REQ-032 Without FETCH_TIMEOUT_EN, fetch_err is tied to 0 and no counter exists; all other behaviour is identical.

Verification
REQ-033 Reset, ack 1 cycle after every req, hazardDetected=0 -> PC sequence 0,4,8,12; each valid_F pulse lasts 1 cycle and instruction equals the memory words in order.
REQ-034 Ack at PC=8, then hazardDetected=1 for 3 cycles -> valid_F, PC=8 and instruction held 4 cycles; fetch of 12 starts the cycle after release.
REQ-035 PCSrcD=1 with PCbranchD=0x100 while fetch of 0x20 waits 4 cycles for ack -> the 0x20 data never reaches instruction; next imem_addr=0x100.
REQ-036 imem_ack and PCSrcD (target 0x40) in the same FETCH cycle -> valid_F stays 0; PC=0x40 the next cycle.
REQ-037 RESET_PC=32'hFFFFFFFC, one fetch consumed -> next PC=0.
REQ-038 FETCH_TIMEOUT_EN defined, TIMEOUT_CYCLES=15, ack withheld -> fetch_err=1 after the 15th FETCH cycle and stays high after a late ack; without the macro, fetch_err=0 throughout.
